reg_scoreboard: RTL and testbench

- Tracks in-flight register writes for the 5-stage RISC-V pipeline.
- Producers are recorded at issue (D->E hand-off) and retired at writeback.
- Counterpart to the forwarding/stall logic: it writes pending-destination state; the forwarding/stall logic reads it.
- Flags D-stage sources whose producer cannot be forwarded (outstanding load), and throttles issue when a register's pending counter is full.

---
 rtl/reg_scoreboard_pkg.sv | 32 +++
 rtl/reg_scoreboard_sb_entry.sv | 64 ++++++
 rtl/reg_scoreboard.sv | 131 +++++++++++++
 tb/tb_reg_scoreboard.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/reg_scoreboard_pkg.sv
`default_nettype none
// ============================================================================
// Module   : reg_scoreboard_pkg
// Brief    : Shared constants for the register scoreboard and hazard unit:
//            register-index width, default sizing and RV32I opcode classes.
// Revision : 1.0 - initial release
// ============================================================================
package reg_scoreboard_pkg;

    // Architectural register index width and default sizing
    localparam int REG_W         = 5;
    localparam int NREGS_DEFAULT = 32;
    localparam int CNT_W_DEFAULT = 2;

    // Instruction-class opcodes, shared with the hazard unit
    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_CAL_R = 7'b0110011;
    localparam logic [6:0] OP_CAL_I = 7'b0010011;
    localparam logic [6:0] OP_STORE = 7'b0100011;

    // Instruction classes that write rd
    function automatic logic op_writes_rd(input logic [6:0] op);
        return (op == OP_LOAD) || (op == OP_CAL_R) || (op == OP_CAL_I);
    endfunction

    // Instruction classes that read rs2
    function automatic logic op_reads_rs2(input logic [6:0] op);
        return (op == OP_CAL_R) || (op == OP_STORE);
    endfunction

endpackage
`default_nettype wire

// File: rtl/reg_scoreboard_sb_entry.sv
`default_nettype none
// ============================================================================
// Module   : sb_entry
// Brief    : One scoreboard slot: pending-write counter plus pending-load
//            counter. Decrements saturate at zero and report underflow.
// Revision : 1.0 - initial release
// ============================================================================
module sb_entry #(
    parameter int CNT_W = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_inc,
    input  logic             i_inc_ld,
    input  logic             i_dec,
    input  logic             i_dec_ld,
    output logic [CNT_W-1:0] o_cnt,
    output logic [CNT_W-1:0] o_ldcnt,
    output logic             o_underflow
);

    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] r_ldcnt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic [CNT_W-1:0] w_ldcnt_nxt;
    logic             w_cnt_uf;
    logic             w_ldcnt_uf;

    assign w_cnt_uf   = i_dec    && (r_cnt   == '0);
    assign w_ldcnt_uf = i_dec_ld && (r_ldcnt == '0);

    // Net next count: an issue and a retire in the same cycle cancel out;
    // a retire against an empty counter is dropped (flagged as underflow).
    always_comb begin
        w_cnt_nxt   = r_cnt   + CNT_W'(i_inc)
                              - CNT_W'(i_dec && !w_cnt_uf);
        w_ldcnt_nxt = r_ldcnt + CNT_W'(i_inc_ld)
                              - CNT_W'(i_dec_ld && !w_ldcnt_uf);
    end

    // Counter state register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt   <= '0;
            r_ldcnt <= '0;
        end else begin
            r_cnt   <= w_cnt_nxt;
            r_ldcnt <= w_ldcnt_nxt;
        end
    end

    // Pending loads are a subset of pending writes
    always_ff @(posedge clk) begin
        if (!rst) begin
            assert (r_ldcnt <= r_cnt);
        end
    end

    assign o_cnt       = r_cnt;
    assign o_ldcnt     = r_ldcnt;
    assign o_underflow = w_cnt_uf || w_ldcnt_uf;

endmodule
`default_nettype wire

// File: rtl/reg_scoreboard.sv
`default_nettype none
// ============================================================================
// Module   : reg_scoreboard
// Brief    : In-flight register-write tracker for the 5-stage pipeline.
//            Records producers at issue, retires them at writeback, stalls
//            D on an outstanding load source or a full pending counter.
//            Optional macro SCOREBOARD_STATS_EN adds stall statistics ports.
// Revision : 1.0 - initial release
// ============================================================================
module reg_scoreboard
    import reg_scoreboard_pkg::*;
#(
    parameter int NREGS = NREGS_DEFAULT,
    parameter int CNT_W = CNT_W_DEFAULT
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             issue_valid,
    input  logic [REG_W-1:0] issue_rd,
    input  logic             issue_wr,
    input  logic             issue_is_load,
    input  logic [REG_W-1:0] issue_rs1,
    input  logic [REG_W-1:0] issue_rs2,
    input  logic             use_rs1,
    input  logic             use_rs2,
    input  logic             flush,
    input  logic             wb_valid,
    input  logic [REG_W-1:0] wb_rd,
    input  logic             wb_is_load,
    output logic             stall,
    output logic [NREGS-1:0] busy_vec,
    output logic             sb_err
`ifdef SCOREBOARD_STATS_EN
    ,
    output logic [31:0]      stall_cycles,
    output logic [31:0]      full_stalls
`endif
);

    localparam logic [CNT_W-1:0] c_CNT_MAX = {CNT_W{1'b1}};

    logic [CNT_W-1:0] w_cnt   [NREGS];
    logic [CNT_W-1:0] w_ldcnt [NREGS];
    logic [NREGS-1:0] w_uf;
    logic             w_rs1_haz;
    logic             w_rs2_haz;
    logic             w_full;
    logic             w_accept;
    logic             w_do_issue;
    logic             w_do_retire;
    logic             r_sb_err;

    // x0 is hard-wired and never tracked
    assign w_cnt[0]   = '0;
    assign w_ldcnt[0] = '0;
    assign w_uf[0]    = 1'b0;
    assign busy_vec[0] = 1'b0;

    assign w_do_issue  = w_accept && issue_wr && (issue_rd != '0);
    assign w_do_retire = wb_valid && (wb_rd != '0);

    generate
        for (genvar i = 1; i < NREGS; i++) begin : g_entry
            logic w_hit_issue;
            logic w_hit_wb;

            assign w_hit_issue = w_do_issue  && (issue_rd == REG_W'(i));
            assign w_hit_wb    = w_do_retire && (wb_rd    == REG_W'(i));

            sb_entry #(
                .CNT_W (CNT_W)
            ) u_entry (
                .clk         (clk),
                .rst         (reset),
                .i_inc       (w_hit_issue),
                .i_inc_ld    (w_hit_issue && issue_is_load),
                .i_dec       (w_hit_wb),
                .i_dec_ld    (w_hit_wb && wb_is_load),
                .o_cnt       (w_cnt[i]),
                .o_ldcnt     (w_ldcnt[i]),
                .o_underflow (w_uf[i])
            );

            assign busy_vec[i] = (w_cnt[i] != '0);
        end
    endgenerate

    // Hazard terms read registered state only, so a same-cycle retire
    // never releases the stall (one-bubble load-use)
    always_comb begin
        w_rs1_haz = use_rs1  && (issue_rs1 != '0) && (w_ldcnt[issue_rs1] != '0);
        w_rs2_haz = use_rs2  && (issue_rs2 != '0) && (w_ldcnt[issue_rs2] != '0);
        w_full    = issue_wr && (issue_rd  != '0) && (w_cnt[issue_rd] == c_CNT_MAX);
        stall     = issue_valid && !flush && (w_rs1_haz || w_rs2_haz || w_full);
        w_accept  = issue_valid && !stall && !flush;
    end

    // Sticky error: any retire against an empty counter
    always_ff @(posedge clk) begin
        if (reset) begin
            r_sb_err <= 1'b0;
        end else if (|w_uf) begin
            r_sb_err <= 1'b1;
        end
    end

    assign sb_err = r_sb_err;

`ifdef SCOREBOARD_STATS_EN
    logic [31:0] r_stall_cycles;
    logic [31:0] r_full_stalls;

    // Stall statistics; full_stalls counts stalls caused by the full term alone
    always_ff @(posedge clk) begin
        if (reset) begin
            r_stall_cycles <= '0;
            r_full_stalls  <= '0;
        end else if (stall) begin
            r_stall_cycles <= r_stall_cycles + 32'd1;
            if (w_full && !w_rs1_haz && !w_rs2_haz) begin
                r_full_stalls <= r_full_stalls + 32'd1;
            end
        end
    end

    assign stall_cycles = r_stall_cycles;
    assign full_stalls  = r_full_stalls;
`endif

endmodule
`default_nettype wire

// File: tb/tb_reg_scoreboard.sv
`default_nettype none
// ============================================================================
// Module   : tb_reg_scoreboard
// Brief    : Directed self-checking bench for reg_scoreboard.
// Revision : 1.0 - initial release
// ============================================================================
module tb_reg_scoreboard;

    logic        clk = 1'b0;
    logic        reset;
    logic        issue_valid;
    logic [4:0]  issue_rd;
    logic        issue_wr;
    logic        issue_is_load;
    logic [4:0]  issue_rs1;
    logic [4:0]  issue_rs2;
    logic        use_rs1;
    logic        use_rs2;
    logic        flush;
    logic        wb_valid;
    logic [4:0]  wb_rd;
    logic        wb_is_load;
    logic        stall;
    logic [31:0] busy_vec;
    logic        sb_err;
`ifdef SCOREBOARD_STATS_EN
    logic [31:0] stall_cycles;
    logic [31:0] full_stalls;
`endif

    int n_pass  = 0;
    int n_total = 0;

    always #5 clk = ~clk;

    reg_scoreboard dut (
        .clk           (clk),
        .reset         (reset),
        .issue_valid   (issue_valid),
        .issue_rd      (issue_rd),
        .issue_wr      (issue_wr),
        .issue_is_load (issue_is_load),
        .issue_rs1     (issue_rs1),
        .issue_rs2     (issue_rs2),
        .use_rs1       (use_rs1),
        .use_rs2       (use_rs2),
        .flush         (flush),
        .wb_valid      (wb_valid),
        .wb_rd         (wb_rd),
        .wb_is_load    (wb_is_load),
        .stall         (stall),
        .busy_vec      (busy_vec),
        .sb_err        (sb_err)
`ifdef SCOREBOARD_STATS_EN
        ,
        .stall_cycles  (stall_cycles),
        .full_stalls   (full_stalls)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic idle();
        reset = 1'b0; issue_valid = 1'b0; issue_rd = 5'd0; issue_wr = 1'b0;
        issue_is_load = 1'b0; issue_rs1 = 5'd0; issue_rs2 = 5'd0;
        use_rs1 = 1'b0; use_rs2 = 1'b0; flush = 1'b0;
        wb_valid = 1'b0; wb_rd = 5'd0; wb_is_load = 1'b0;
    endtask

    task automatic issue(input logic [4:0] rd, input logic ld);
        issue_valid = 1'b1; issue_wr = 1'b1; issue_rd = rd; issue_is_load = ld;
    endtask

    task automatic retire(input logic [4:0] rd, input logic ld);
        wb_valid = 1'b1; wb_rd = rd; wb_is_load = ld;
    endtask

    // Advance one clock, land 1 ns after the edge; settle inputs with #3
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        idle();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        #3;
        chk("rst_busy",  busy_vec, 32'h0);
        chk("rst_stall", {31'b0, stall}, 32'd0);
        chk("rst_err",   {31'b0, sb_err}, 32'd0);

        // Load then use
        idle(); issue(5'd5, 1'b1); #3;
        chk("lw_issue_stall", {31'b0, stall}, 32'd0);
        tick();
        idle(); issue(5'd6, 1'b0); issue_rs1 = 5'd5; use_rs1 = 1'b1; #3;
        chk("lu_stall", {31'b0, stall}, 32'd1);
        chk("lu_busy", busy_vec, 32'h0000_0020);
        tick(); #3;
        chk("lu_stall_hold", {31'b0, stall}, 32'd1);
        retire(5'd5, 1'b1); #1;
        chk("lu_wb_same_cycle", {31'b0, stall}, 32'd1);
        tick();
        wb_valid = 1'b0; #3;
        chk("lu_release", {31'b0, stall}, 32'd0);
        chk("lu_busy_clear", busy_vec, 32'h0);
        tick();

        // ALU then use: forwardable, no stall
        idle(); issue(5'd8, 1'b0); issue_rs2 = 5'd6; use_rs2 = 1'b1; #3;
        chk("alu_fwd_stall", {31'b0, stall}, 32'd0);
        chk("alu_busy", busy_vec, 32'h0000_0040);
        tick();
        idle(); retire(5'd6, 1'b0); tick();
        idle(); retire(5'd8, 1'b0); tick();
        idle(); #3;
        chk("alu_retired", busy_vec, 32'h0);

        // x0 writes are never tracked
        idle(); issue(5'd0, 1'b1);
        for (int k = 0; k < 3; k++) tick();
        idle(); issue(5'd10, 1'b0); issue_rs1 = 5'd0; use_rs1 = 1'b1; #3;
        chk("x0_stall", {31'b0, stall}, 32'd0);
        chk("x0_busy", busy_vec, 32'h0);
        tick();
        idle(); retire(5'd10, 1'b0); tick();

        // Full counter on x9
        idle(); issue(5'd9, 1'b0);
        for (int k = 0; k < 3; k++) tick();
        #3;
        chk("full_stall", {31'b0, stall}, 32'd1);
        chk("full_busy", busy_vec, 32'h0000_0200);
        issue_valid = 1'b0; #1;
        chk("full_gated", {31'b0, stall}, 32'd0);
        issue_valid = 1'b1;
        retire(5'd9, 1'b0); #1;
        chk("full_wb_same", {31'b0, stall}, 32'd1);
        tick();
        wb_valid = 1'b0; #3;
        chk("full_release", {31'b0, stall}, 32'd0);
        tick();
        idle(); issue(5'd9, 1'b0); #3;
        chk("full_again", {31'b0, stall}, 32'd1);
        idle(); retire(5'd9, 1'b0);
        for (int k = 0; k < 3; k++) tick();
        idle(); #3;
        chk("full_drained", busy_vec, 32'h0);

        // Simultaneous issue/retire on x4 with one pending
        idle(); issue(5'd4, 1'b0); tick();
        retire(5'd4, 1'b0); tick();
        idle(); #3;
        chk("simul_busy", busy_vec, 32'h0000_0010);
        retire(5'd4, 1'b0); tick();
        idle(); #3;
        chk("simul_net", busy_vec, 32'h0);
        chk("simul_no_err", {31'b0, sb_err}, 32'd0);

        // Underflow on x12
        retire(5'd12, 1'b0); tick();
        idle(); #3;
        chk("uf_err", {31'b0, sb_err}, 32'd1);
        chk("uf_sat", busy_vec, 32'h0);
        tick(); tick(); #3;
        chk("uf_sticky", {31'b0, sb_err}, 32'd1);

        // Flush: no stall, no state change
        idle(); issue(5'd5, 1'b1); tick();
        idle(); issue(5'd3, 1'b0); issue_rs1 = 5'd5; use_rs1 = 1'b1; flush = 1'b1; #3;
        chk("flush_stall", {31'b0, stall}, 32'd0);
        tick();
        idle(); #3;
        chk("flush_state", busy_vec, 32'h0000_0020);

        // Reset with pending loads and an in-flight retire
        issue(5'd7, 1'b1); tick();
        idle(); #3;
        chk("pre_rst_busy", busy_vec, 32'h0000_00A0);
        reset = 1'b1; retire(5'd5, 1'b1); tick();
        idle(); issue(5'd6, 1'b0); issue_rs1 = 5'd7; use_rs1 = 1'b1; #3;
        chk("mid_rst_busy",  busy_vec, 32'h0);
        chk("mid_rst_stall", {31'b0, stall}, 32'd0);
        chk("mid_rst_err",   {31'b0, sb_err}, 32'd0);
        tick();
        idle();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
